// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and widths for the N5 bus fabric.
package ahb_pkg;

  localparam int AHB_AW = 32;
  localparam int AHB_DW = 32;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

endpackage

// File: rtl/ahb_lite_master_if.sv
// Command/response stream plus AHB-Lite bus signals seen by the initiator.
interface ahb_lite_master_if;
  import ahb_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [AHB_AW-1:0] cmd_addr;
  logic              cmd_write;
  logic [2:0]        cmd_size;
  logic [AHB_DW-1:0] cmd_wdata;

  logic              rsp_valid;
  logic [AHB_DW-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_cancel;
  logic              busy;

  logic [AHB_AW-1:0] HADDR;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic [2:0]        HBURST;
  logic [3:0]        HPROT;
  logic [AHB_DW-1:0] HWDATA;
  logic              HREADY;
  logic [1:0]        HRESP;
  logic [AHB_DW-1:0] HRDATA;

  modport master (
    input  cmd_valid, cmd_addr, cmd_write, cmd_size, cmd_wdata,
    input  HREADY, HRESP, HRDATA,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_cancel, busy,
    output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_write, cmd_size, cmd_wdata,
    output HREADY, HRESP, HRDATA,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_cancel, busy,
    input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA
  );

endinterface

// File: rtl/ahb_lite_master.sv
// Pipelined single-transfer AHB-Lite initiator: one command in address phase
// overlapping one in data phase, responses returned in order.
module ahb_lite_master
  import ahb_pkg::*;
#(
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input logic               HCLK,
  input logic               HRESETn,
  ahb_lite_master_if.master bus
);

  logic              dph_valid;
  logic              dph_write;
  logic              cancel_pending;
  logic [AHB_DW-1:0] wdata_hold;
  logic              addr_nonseq;
  logic              err_cycle1;
  logic              accept;
  logic              dph_done;

  assign addr_nonseq   = (bus.HTRANS == HTRANS_NONSEQ);
  assign err_cycle1    = dph_valid & bus.HRESP[0] & ~bus.HREADY;
  assign dph_done      = dph_valid & bus.HREADY;
  assign bus.cmd_ready = bus.HREADY & ~err_cycle1 & ~cancel_pending;
  assign accept        = bus.cmd_valid & bus.cmd_ready;
  assign bus.busy      = addr_nonseq | dph_valid | cancel_pending;
  assign bus.HBURST    = HBURST_SINGLE;
  assign bus.HPROT     = HPROT_VAL;

  // The first ERROR cycle withdraws a pending NONSEQ so it never reaches the bus.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      bus.HTRANS <= HTRANS_IDLE;
      bus.HADDR  <= '0;
      bus.HWRITE <= 1'b0;
      bus.HSIZE  <= HSIZE_WORD;
      wdata_hold <= '0;
    end else if (accept) begin
      bus.HTRANS <= HTRANS_NONSEQ;
      bus.HADDR  <= bus.cmd_addr;
      bus.HWRITE <= bus.cmd_write;
      bus.HSIZE  <= bus.cmd_size;
      wdata_hold <= bus.cmd_wdata;
    end else if (bus.HREADY || err_cycle1) begin
      bus.HTRANS <= HTRANS_IDLE;
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      dph_valid  <= 1'b0;
      dph_write  <= 1'b0;
      bus.HWDATA <= '0;
    end else if (bus.HREADY) begin
      dph_valid <= addr_nonseq;
      if (addr_nonseq) begin
        dph_write  <= bus.HWRITE;
        bus.HWDATA <= wdata_hold;
      end
    end
  end

  // The dropped command answers right after the erroring transfer's response.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      cancel_pending <= 1'b0;
    end else if (err_cycle1 && addr_nonseq) begin
      cancel_pending <= 1'b1;
    end else if (cancel_pending && !dph_done) begin
      cancel_pending <= 1'b0;
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      bus.rsp_valid  <= 1'b0;
      bus.rsp_rdata  <= '0;
      bus.rsp_err    <= 1'b0;
      bus.rsp_cancel <= 1'b0;
    end else begin
      bus.rsp_valid  <= 1'b0;
      bus.rsp_rdata  <= '0;
      bus.rsp_err    <= 1'b0;
      bus.rsp_cancel <= 1'b0;
      if (dph_done) begin
        bus.rsp_valid <= 1'b1;
        bus.rsp_err   <= bus.HRESP[0];
        bus.rsp_rdata <= (!dph_write && !bus.HRESP[0]) ? bus.HRDATA : '0;
      end else if (cancel_pending) begin
        bus.rsp_valid  <= 1'b1;
        bus.rsp_err    <= 1'b1;
        bus.rsp_cancel <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed scenarios plus randomized traffic against a transaction-level
// model of the initiator's pipeline, checked on every cycle.
module tb_ahb_lite_master;
  import ahb_pkg::*;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
    logic [31:0] wdata;
  } cmd_t;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  always #5 HCLK = ~HCLK;

  ahb_lite_master_if bus();

  ahb_lite_master #(.HPROT_VAL(4'b0011)) dut (
    .HCLK   (HCLK),
    .HRESETn(HRESETn),
    .bus    (bus)
  );

  // Model: which command sits in each bus phase and what must come out next.
  bit          known = 0;
  bit          post_reset = 0;
  bit          a_v = 0, d_v = 0, c_v = 0, r_v = 0;
  cmd_t        a_cmd, d_cmd;
  logic [31:0] r_rdata = '0;
  bit          r_err = 0, r_cancel = 0;
  bit          last_accept = 0;
  bit          err2 = 0;

  int vectors = 0;
  int miscompares = 0;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit expReady();
    return bus.HREADY && !(d_v && bus.HRESP[0] && !bus.HREADY) && !c_v;
  endfunction

  task automatic checkOutput();
    if (!known) return;
    checkBit("cmd_ready", bus.cmd_ready, expReady());
    checkBit("busy", bus.busy, a_v | d_v | c_v);
    checkVal("HTRANS", 32'(bus.HTRANS), a_v ? 32'(HTRANS_NONSEQ) : 32'(HTRANS_IDLE));
    checkVal("HBURST", 32'(bus.HBURST), 32'd0);
    checkVal("HPROT", 32'(bus.HPROT), 32'h3);
    checkBit("rsp_valid", bus.rsp_valid, r_v);
    if (r_v) begin
      checkVal("rsp_rdata", bus.rsp_rdata, r_rdata);
      checkBit("rsp_err", bus.rsp_err, r_err);
      checkBit("rsp_cancel", bus.rsp_cancel, r_cancel);
    end
    if (a_v) begin
      checkVal("HADDR", bus.HADDR, a_cmd.addr);
      checkBit("HWRITE", bus.HWRITE, a_cmd.write);
      checkVal("HSIZE", 32'(bus.HSIZE), 32'(a_cmd.size));
    end
    if (d_v) checkVal("HWDATA", bus.HWDATA, d_cmd.wdata);
    if (post_reset) begin
      checkVal("reset HADDR", bus.HADDR, 32'd0);
      checkBit("reset HWRITE", bus.HWRITE, 1'b0);
      checkVal("reset HSIZE", 32'(bus.HSIZE), 32'd2);
      checkVal("reset HWDATA", bus.HWDATA, 32'd0);
      checkVal("reset rsp_rdata", bus.rsp_rdata, 32'd0);
      checkBit("reset rsp_err", bus.rsp_err, 1'b0);
      checkBit("reset rsp_cancel", bus.rsp_cancel, 1'b0);
    end
  endtask

  task automatic modelUpdate();
    bit   hr, acc, err1;
    cmd_t nc;
    if (!HRESETn) begin
      known = 1; post_reset = 1; last_accept = 0;
      a_v = 0; d_v = 0; c_v = 0; r_v = 0;
      return;
    end
    if (!known) return;
    post_reset = 0;
    hr   = bus.HREADY;
    acc  = bus.cmd_valid && expReady();
    err1 = d_v && bus.HRESP[0] && !hr;
    last_accept = acc;
    nc = '{addr: bus.cmd_addr, write: bus.cmd_write, size: bus.cmd_size, wdata: bus.cmd_wdata};
    r_v = 0; r_rdata = '0; r_err = 0; r_cancel = 0;
    if (d_v && hr) begin
      r_v = 1;
      r_err = bus.HRESP[0];
      r_rdata = (!d_cmd.write && !bus.HRESP[0]) ? bus.HRDATA : 32'd0;
    end else if (c_v) begin
      r_v = 1; r_err = 1; r_cancel = 1; c_v = 0;
    end
    if (err1 && a_v) c_v = 1;
    if (hr) begin
      d_v = a_v;
      d_cmd = a_cmd;
    end
    if (acc) begin
      a_v = 1;
      a_cmd = nc;
    end else if (hr || err1) begin
      a_v = 0;
    end
  endtask

  task automatic stepCycle();
    @(negedge HCLK);
    checkOutput();
    modelUpdate();
    @(posedge HCLK);
    #1;
  endtask

  task automatic applyStimulus(input bit v, input logic [31:0] addr, input bit wr,
                               input logic [2:0] sz, input logic [31:0] wd,
                               input bit hready, input logic [1:0] hresp,
                               input logic [31:0] hrdata, input bit rstn);
    bus.cmd_valid = v;
    bus.cmd_addr  = addr;
    bus.cmd_write = wr;
    bus.cmd_size  = sz;
    bus.cmd_wdata = wd;
    bus.HREADY    = hready;
    bus.HRESP     = hresp;
    bus.HRDATA    = hrdata;
    HRESETn       = rstn;
    stepCycle();
  endtask

  task automatic idle(input int n, input logic [31:0] hrdata);
    for (int i = 0; i < n; i++) applyStimulus(0, 32'h0, 0, HSIZE_WORD, 32'h0, 1, HRESP_OKAY, hrdata, 1);
  endtask

  initial begin
    logic [31:0] a, wd, rd;
    logic [2:0]  sz;
    bit          v, w, hr, rstn;
    logic [1:0]  resp;

    bus.cmd_valid = 0; bus.cmd_addr = '0; bus.cmd_write = 0; bus.cmd_size = HSIZE_WORD;
    bus.cmd_wdata = '0; bus.HREADY = 1; bus.HRESP = HRESP_OKAY; bus.HRDATA = '0;
    @(posedge HCLK);
    #1;
    applyStimulus(0, 0, 0, HSIZE_WORD, 0, 1, HRESP_OKAY, 0, 0);
    applyStimulus(0, 0, 0, HSIZE_WORD, 0, 1, HRESP_OKAY, 0, 0);
    idle(1, 0);

    $display("[TB] zero-wait read");
    applyStimulus(1, 32'h40, 0, HSIZE_WORD, 0, 1, HRESP_OKAY, 0, 1);
    checkVal("t1 HTRANS", 32'(bus.HTRANS), 32'(HTRANS_NONSEQ));
    checkVal("t1 HADDR", bus.HADDR, 32'h40);
    applyStimulus(0, 0, 0, HSIZE_WORD, 0, 1, HRESP_OKAY, 0, 1);
    applyStimulus(0, 0, 0, HSIZE_WORD, 0, 1, HRESP_OKAY, 32'hDEADBEEF, 1);
    checkBit("t1 rsp_valid", bus.rsp_valid, 1'b1);
    checkVal("t1 rsp_rdata", bus.rsp_rdata, 32'hDEADBEEF);
    checkBit("t1 rsp_err", bus.rsp_err, 1'b0);
    idle(2, 0);

    $display("[TB] back-to-back writes");
    for (int i = 0; i < 4; i++)
      applyStimulus(1, 32'h100 + 32'(4 * i), 1, HSIZE_WORD, 32'hA000_0000 + 32'(i), 1, HRESP_OKAY, 0, 1);
    checkVal("t2 HADDR", bus.HADDR, 32'h10C);
    checkVal("t2 HWDATA lag", bus.HWDATA, 32'hA000_0002);
    checkBit("t2 rsp_valid", bus.rsp_valid, 1'b1);
    checkVal("t2 rsp_rdata", bus.rsp_rdata, 32'h0);
    idle(4, 0);

    $display("[TB] wait-stated read");
    applyStimulus(1, 32'h300, 0, HSIZE_WORD, 0, 1, HRESP_OKAY, 0, 1);
    applyStimulus(1, 32'h304, 1, HSIZE_HALF, 32'h1111, 1, HRESP_OKAY, 0, 1);
    applyStimulus(1, 32'h308, 0, HSIZE_BYTE, 0, 0, HRESP_OKAY, 0, 1);
    applyStimulus(1, 32'h308, 0, HSIZE_BYTE, 0, 0, HRESP_OKAY, 0, 1);
    checkVal("t3 held HADDR", bus.HADDR, 32'h304);
    checkBit("t3 cmd_ready", bus.cmd_ready, 1'b0);
    applyStimulus(1, 32'h308, 0, HSIZE_BYTE, 0, 0, HRESP_OKAY, 0, 1);
    applyStimulus(1, 32'h308, 0, HSIZE_BYTE, 0, 1, HRESP_OKAY, 32'h12345678, 1);
    checkBit("t3 rsp_valid", bus.rsp_valid, 1'b1);
    checkVal("t3 rsp_rdata", bus.rsp_rdata, 32'h12345678);
    idle(4, 0);

    $display("[TB] error with pending command");
    applyStimulus(1, 32'h200, 1, HSIZE_WORD, 32'hCAFE0200, 1, HRESP_OKAY, 0, 1);
    applyStimulus(1, 32'h204, 0, HSIZE_WORD, 0, 1, HRESP_OKAY, 0, 1);
    applyStimulus(0, 0, 0, HSIZE_WORD, 0, 0, HRESP_ERROR, 0, 1);
    checkVal("t4 HTRANS idle", 32'(bus.HTRANS), 32'(HTRANS_IDLE));
    checkBit("t4 busy", bus.busy, 1'b1);
    applyStimulus(0, 0, 0, HSIZE_WORD, 0, 1, HRESP_ERROR, 0, 1);
    checkBit("t4 err rsp_valid", bus.rsp_valid, 1'b1);
    checkBit("t4 err rsp_err", bus.rsp_err, 1'b1);
    checkBit("t4 err rsp_cancel", bus.rsp_cancel, 1'b0);
    applyStimulus(0, 0, 0, HSIZE_WORD, 0, 1, HRESP_OKAY, 0, 1);
    checkBit("t4 cancel rsp_valid", bus.rsp_valid, 1'b1);
    checkBit("t4 cancel rsp_err", bus.rsp_err, 1'b1);
    checkBit("t4 cancel rsp_cancel", bus.rsp_cancel, 1'b1);
    applyStimulus(0, 0, 0, HSIZE_WORD, 0, 1, HRESP_OKAY, 0, 1);
    checkBit("t4 rsp done", bus.rsp_valid, 1'b0);
    checkBit("t4 idle busy", bus.busy, 1'b0);
    idle(2, 0);

    $display("[TB] reset during wait state");
    applyStimulus(1, 32'h400, 0, HSIZE_WORD, 0, 1, HRESP_OKAY, 0, 1);
    applyStimulus(0, 0, 0, HSIZE_WORD, 0, 1, HRESP_OKAY, 0, 1);
    applyStimulus(0, 0, 0, HSIZE_WORD, 0, 0, HRESP_OKAY, 0, 1);
    applyStimulus(0, 0, 0, HSIZE_WORD, 0, 0, HRESP_OKAY, 0, 0);
    checkVal("t5 HTRANS", 32'(bus.HTRANS), 32'(HTRANS_IDLE));
    checkBit("t5 busy", bus.busy, 1'b0);
    checkBit("t5 rsp_valid", bus.rsp_valid, 1'b0);
    applyStimulus(1, 32'h404, 0, HSIZE_WORD, 0, 1, HRESP_OKAY, 0, 1);
    applyStimulus(0, 0, 0, HSIZE_WORD, 0, 1, HRESP_OKAY, 0, 1);
    applyStimulus(0, 0, 0, HSIZE_WORD, 0, 1, HRESP_OKAY, 32'h55AA55AA, 1);
    checkBit("t5 rsp_valid", bus.rsp_valid, 1'b1);
    checkVal("t5 rsp_rdata", bus.rsp_rdata, 32'h55AA55AA);
    idle(2, 0);

    $display("[TB] command while HREADY low");
    applyStimulus(1, 32'h500, 0, HSIZE_WORD, 0, 0, HRESP_OKAY, 0, 1);
    checkVal("t6 HTRANS", 32'(bus.HTRANS), 32'(HTRANS_IDLE));
    applyStimulus(1, 32'h500, 0, HSIZE_WORD, 0, 0, HRESP_OKAY, 0, 1);
    applyStimulus(1, 32'h500, 0, HSIZE_WORD, 0, 1, HRESP_OKAY, 0, 1);
    checkVal("t6 HTRANS", 32'(bus.HTRANS), 32'(HTRANS_NONSEQ));
    idle(4, 32'h0BAD0BAD);

    $display("[TB] random traffic");
    for (int n = 0; n < 3000; n++) begin
      if (bus.cmd_valid && !last_accept) begin
        v = 1; a = bus.cmd_addr; w = bus.cmd_write; sz = bus.cmd_size; wd = bus.cmd_wdata;
      end else begin
        v  = ($urandom_range(0, 9) < 6);
        sz = 3'($urandom_range(0, 2));
        a  = $urandom;
        a  = a & ~((32'd1 << sz) - 32'd1);
        w  = 1'($urandom_range(0, 1));
        wd = $urandom;
      end
      if (err2) begin
        hr = 1; resp = HRESP_ERROR; err2 = 0;
      end else if (d_v && $urandom_range(0, 9) == 0) begin
        hr = 0; resp = HRESP_ERROR; err2 = 1;
      end else begin
        hr = ($urandom_range(0, 3) != 0); resp = HRESP_OKAY;
      end
      rd   = $urandom;
      rstn = ($urandom_range(0, 199) != 0);
      if (!rstn) err2 = 0;
      applyStimulus(v, a, w, sz, wd, hr, resp, rd, rstn);
    end
    idle(4, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
